// File: rtl/pwm_timer_pkg.sv
// Shared constants for the multi-channel PWM timer.
// Counting mode and direction encodings.
package pwm_timer_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;
    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;

endpackage

// File: rtl/pwm_timer_multi_if.sv
// Control/status bundle between register block and PWM timer.
// master = register block side, slave = timer side.
interface pwm_timer_multi_if #(
    parameter int BITS       = 32,
    parameter int CHANNELS   = 4,
    parameter int PRESC_BITS = 8
);
    logic                     enable;
    logic                     mode;
    logic [PRESC_BITS-1:0]    prescale;
    logic [BITS-1:0]          reload_cnt;
    logic [CHANNELS*BITS-1:0] threshold;
    logic [CHANNELS-1:0]      ch_en;
    logic [CHANNELS-1:0]      polarity;
    logic                     update_req;
    logic [CHANNELS-1:0]      channel;
    logic                     period_tick;
    logic                     update_done;
    logic [BITS-1:0]          counter_out;

    modport master (
        output enable, mode, prescale, reload_cnt, threshold,
        output ch_en, polarity, update_req,
        input  channel, period_tick, update_done, counter_out
    );

    modport slave (
        input  enable, mode, prescale, reload_cnt, threshold,
        input  ch_en, polarity, update_req,
        output channel, period_tick, update_done, counter_out
    );
endinterface

// File: rtl/pwm_timer_channel.sv
// One compare output: registered, enable- and polarity-aware.
// Idle level (polarity) whenever the timer or channel is off.
module pwm_timer_channel #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_run,
    input  logic [BITS-1:0] i_cnt,
    input  logic [BITS-1:0] i_thr,
    input  logic            i_en,
    input  logic            i_pol,
    output logic            o_ch
);
    logic w_raw;

    assign w_raw = (i_cnt >= i_thr);

    // Output register: compare result or idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_ch <= 1'b0;
        end else if (i_run && i_en) begin
            o_ch <= w_raw ^ i_pol;
        end else begin
            o_ch <= i_pol;
        end
    end
endmodule

// File: rtl/pwm_timer_multi.sv
// Multi-channel PWM timer: prescaler, shared edge/centre counter,
// shadowed configuration applied at period boundaries.
module pwm_timer_multi
    import pwm_timer_pkg::*;
#(
    parameter int BITS       = 32,
    parameter int CHANNELS   = 4,
    parameter int PRESC_BITS = 8
) (
    input logic              clk,
    input logic              rst_n,
    pwm_timer_multi_if.slave bus
);
    logic [PRESC_BITS-1:0]    r_pcnt;
    logic [PRESC_BITS-1:0]    r_presc;
    logic [BITS-1:0]          r_cnt;
    logic [BITS-1:0]          r_reload;
    logic [CHANNELS*BITS-1:0] r_thr;
    logic                     r_mode;
    logic                     r_dir;
    logic                     r_pending;
    logic                     r_tick;
    logic                     r_done;
    logic [BITS-1:0]          w_cnt_nxt;
    logic                     w_dir_nxt;
    logic                     w_step;
    logic                     w_bnd;
    logic                     w_xfer;
    logic                     w_restart;
    logic [CHANNELS-1:0]      w_ch;

    assign w_step = bus.enable && (r_pcnt == r_presc);

    // Next counter/direction and period boundary for the current step.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        w_bnd     = 1'b0;
        if (w_step) begin
            if (r_reload == '0) begin
                w_cnt_nxt = '0;
                w_dir_nxt = DIR_UP;
                w_bnd     = 1'b1;
            end else if (r_mode == MODE_EDGE) begin
                if (r_cnt == r_reload) begin
                    w_cnt_nxt = '0;
                    w_bnd     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + BITS'(1);
                end
            end else if (r_dir == DIR_UP) begin
                if (r_cnt == r_reload) begin
                    w_dir_nxt = DIR_DOWN;
                    w_cnt_nxt = r_cnt - BITS'(1);
                end else begin
                    w_cnt_nxt = r_cnt + BITS'(1);
                end
            end else begin
                if (r_cnt == '0) begin
                    w_bnd     = 1'b1;
                    w_dir_nxt = DIR_UP;
                    w_cnt_nxt = BITS'(1);
                end else begin
                    w_cnt_nxt = r_cnt - BITS'(1);
                end
            end
        end
    end

    // Transfer at a boundary, or straight away while stopped.
    assign w_xfer = (r_pending || bus.update_req) &&
                    (w_bnd || !bus.enable);

    // A new mode or zero reload restarts counting from 0, upward.
    assign w_restart = w_xfer &&
                       ((bus.mode != r_mode) || (bus.reload_cnt == '0));

    // Prescaler, counter and direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= '0;
            r_cnt  <= '0;
            r_dir  <= DIR_UP;
        end else if (!bus.enable) begin
            r_pcnt <= '0;
            r_cnt  <= '0;
            r_dir  <= DIR_UP;
        end else begin
            r_pcnt <= (r_pcnt == r_presc) ? '0 : r_pcnt + PRESC_BITS'(1);
            r_cnt  <= w_restart ? '0 : w_cnt_nxt;
            r_dir  <= w_restart ? DIR_UP : w_dir_nxt;
        end
    end

    // Active configuration, pending flag and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_reload  <= '0;
            r_thr     <= '0;
            r_mode    <= MODE_EDGE;
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_presc  <= bus.prescale;
                r_reload <= bus.reload_cnt;
                r_thr    <= bus.threshold;
                r_mode   <= bus.mode;
            end
            if (w_xfer) begin
                r_pending <= 1'b0;
            end else if (bus.update_req) begin
                r_pending <= 1'b1;
            end
            r_tick <= w_bnd;
            r_done <= w_xfer;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_timer_channel #(.BITS(BITS)) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .i_run (bus.enable),
            .i_cnt (r_cnt),
            .i_thr (r_thr[i*BITS +: BITS]),
            .i_en  (bus.ch_en[i]),
            .i_pol (bus.polarity[i]),
            .o_ch  (w_ch[i])
        );
    end

    assign bus.channel     = w_ch;
    assign bus.period_tick = r_tick;
    assign bus.update_done = r_done;
    assign bus.counter_out = r_cnt;
endmodule

// File: tb/tb_pwm_timer_multi.sv
// Directed bench for pwm_timer_multi.
// Hand-computed counts of highs, ticks and period lengths.
module tb_pwm_timer_multi;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   hi [4];
    int   nt;
    int   nd;
    int   n;
    int   exp_c [8];

    pwm_timer_multi_if #(.BITS(32), .CHANNELS(4), .PRESC_BITS(8)) bus ();

    pwm_timer_multi #(.BITS(32), .CHANNELS(4), .PRESC_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step1();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int cycles);
        nt = 0;
        nd = 0;
        for (int c = 0; c < 4; c++) hi[c] = 0;
        repeat (cycles) begin
            step1();
            for (int c = 0; c < 4; c++) if (bus.channel[c]) hi[c]++;
            if (bus.period_tick) nt++;
            if (bus.update_done) nd++;
        end
    endtask

    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            step1();
            cyc++;
        end while (!bus.period_tick && cyc < 200);
    endtask

    task automatic cfg(input logic m, input int ps, input int rl);
        bus.mode       = m;
        bus.prescale   = 8'(ps);
        bus.reload_cnt = 32'(rl);
        bus.threshold  = {32'd5, 32'd12, 32'd0, 32'd3};
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.enable = 1'b0;
        bus.mode = 1'b0;
        bus.prescale = '0;
        bus.reload_cnt = '0;
        bus.threshold = '0;
        bus.ch_en = '0;
        bus.polarity = '0;
        bus.update_req = 1'b0;
        exp_c = '{2, 3, 4, 3, 2, 1, 0, 1};
        step1();
        step1();
        chk("rst_ch", bus.channel, 0);
        chk("rst_cnt", bus.counter_out, 0);
        chk("rst_tick", bus.period_tick, 0);
        chk("rst_done", bus.update_done, 0);
        rst_n = 1'b1;

        // edge, presc 0, reload 9; load while stopped
        cfg(1'b0, 0, 9);
        bus.ch_en = 4'b1111;
        bus.update_req = 1'b1;
        step1();
        chk("stop_xfer_done", bus.update_done, 1);
        bus.update_req = 1'b0;
        step1();
        chk("done_pulse_end", bus.update_done, 0);
        bus.enable = 1'b1;
        step1();
        chk("edge_first_cnt", bus.counter_out, 1);
        run(9);
        chk("edge_wrap_cnt", bus.counter_out, 0);
        chk("edge_wrap_tick", bus.period_tick, 1);
        run(10);
        chk("edge_ch0_hi", hi[0], 7);
        chk("thr0_ch1_hi", hi[1], 10);
        chk("thr12_ch2_hi", hi[2], 0);
        chk("thr5_ch3_hi", hi[3], 5);
        chk("edge_ticks", nt, 1);
        wait_tick(n);
        chk("edge_period", n, 10);

        // update mid-period: reload 9 -> 4
        run(3);
        chk("mid_cnt", bus.counter_out, 3);
        bus.reload_cnt = 32'd4;
        bus.update_req = 1'b1;
        step1();
        bus.update_req = 1'b0;
        chk("pend_no_done", bus.update_done, 0);
        wait_tick(n);
        chk("old_period_rest", n, 6);
        chk("done_at_wrap", bus.update_done, 1);
        wait_tick(n);
        chk("new_period", n, 5);

        // update_req coincident with wrap
        run(4);
        chk("pre_wrap_cnt", bus.counter_out, 4);
        bus.reload_cnt = 32'd9;
        bus.update_req = 1'b1;
        step1();
        bus.update_req = 1'b0;
        chk("coinc_done", bus.update_done, 1);
        chk("coinc_tick", bus.period_tick, 1);
        wait_tick(n);
        chk("coinc_period", n, 10);

        // polarity and channel enable, not shadowed
        bus.polarity = 4'b1111;
        bus.ch_en = 4'b0111;
        step1();
        run(10);
        chk("pol_ch0_hi", hi[0], 3);
        chk("pol_ch1_hi", hi[1], 0);
        chk("pol_ch2_hi", hi[2], 10);
        chk("dis_ch3_hi", hi[3], 10);

        // centre, reload 4, thr0 2
        bus.polarity = 4'b0000;
        bus.ch_en = 4'b1111;
        cfg(1'b1, 0, 4);
        bus.threshold[31:0] = 32'd2;
        bus.update_req = 1'b1;
        wait_tick(n);
        bus.update_req = 1'b0;
        chk("ctr_xfer_done", bus.update_done, 1);
        chk("ctr_restart_cnt", bus.counter_out, 0);
        wait_tick(n);
        chk("ctr_first_period", n, 9);
        chk("ctr_bnd_cnt", bus.counter_out, 1);
        hi[0] = 0;
        for (int k = 0; k < 8; k++) begin
            step1();
            if (bus.channel[0]) hi[0]++;
            chk($sformatf("ctr_seq%0d", k), bus.counter_out, exp_c[k]);
        end
        chk("ctr_ch0_hi", hi[0], 5);
        chk("ctr_period_tick", bus.period_tick, 1);

        // prescale 3, edge, reload 1
        cfg(1'b0, 3, 1);
        bus.update_req = 1'b1;
        wait_tick(n);
        bus.update_req = 1'b0;
        chk("presc_xfer_done", bus.update_done, 1);
        run(3);
        chk("presc_hold_cnt", bus.counter_out, 0);
        step1();
        chk("presc_step_cnt", bus.counter_out, 1);
        wait_tick(n);
        chk("presc_rest", n, 4);
        wait_tick(n);
        chk("presc_period", n, 8);

        // enable drop mid-count
        step1();
        step1();
        bus.enable = 1'b0;
        bus.polarity = 4'b0101;
        step1();
        chk("stop_cnt", bus.counter_out, 0);
        chk("stop_ch_idle", bus.channel, 4'b0101);
        chk("stop_tick", bus.period_tick, 0);
        cfg(1'b0, 0, 9);
        bus.update_req = 1'b1;
        step1();
        bus.update_req = 1'b0;
        chk("stop_done", bus.update_done, 1);
        run(3);
        chk("stop_no_tick", nt, 0);
        bus.enable = 1'b1;
        wait_tick(n);
        chk("resume_period", n, 10);

        // async reset mid-period with pending update
        run(4);
        bus.reload_cnt = 32'd4;
        bus.update_req = 1'b1;
        step1();
        bus.update_req = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_cnt", bus.counter_out, 0);
        chk("arst_ch", bus.channel, 0);
        chk("arst_tick", bus.period_tick, 0);
        chk("arst_done", bus.update_done, 0);
        step1();
        rst_n = 1'b1;
        run(5);
        chk("r0_ticks", nt, 5);
        chk("pending_lost", nd, 0);
        chk("r0_thr0_ch", bus.channel, 4'b1010);
        bus.reload_cnt = 32'd9;
        bus.update_req = 1'b1;
        step1();
        bus.update_req = 1'b0;
        chk("post_rst_done", bus.update_done, 1);
        wait_tick(n);
        chk("post_rst_period", n, 10);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
